// File: rtl/iter_shift_unit_if.sv
// Handshake and data bundle between the EX-stage requester and the
// iterative shift sequencer.
interface iter_shift_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [4:0]  shamt;
    logic [31:0] data_in;
    logic [31:0] result;
    logic        busy;
    logic        done;

    // Requester side: issues shifts, watches busy/done/result.
    modport master (
        output start, op, shamt, data_in,
        input  result, busy, done
    );

    // Sequencer side.
    modport slave (
        input  start, op, shamt, data_in,
        output result, busy, done
    );
endinterface

// File: rtl/iter_shift_unit.sv
// Multi-cycle shift sequencer for SLL/SRL/SRA. A working register is
// stepped by 2 (or 1 for the final odd bit) each cycle under a small
// IDLE/SHIFT/DONE FSM, replacing a full barrel shifter. Busy stalls the
// pipeline while a shift is in flight; Done pulses for one cycle when
// Result has been loaded.
module iter_shift_unit (
    input  logic               clk_i,
    input  logic               rst_i,
    iter_shift_unit_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    state_t      state_q, state_d;
    logic [31:0] w_q, w_d;
    logic [4:0]  r_q, r_d;
    logic [1:0]  l_q, l_d;
    logic [31:0] result_q, result_d;

    logic        two_step;
    logic [4:0]  r_next;
    logic [31:0] w_shifted;

    // One shift step of 1 or 2 bit positions. For SRA both vacated bits
    // take the sign bit of the value before the step.
    function automatic logic [31:0] shift_step(input logic [31:0] w,
                                               input logic [1:0]  op,
                                               input logic        two);
        logic [31:0] res;
        case (op)
            OP_SLL:  res = two ? {w[29:0], 2'b00} : {w[30:0], 1'b0};
            OP_SRL:  res = two ? {2'b00, w[31:2]} : {1'b0, w[31:1]};
            OP_SRA:  res = two ? {w[31], w[31], w[31:2]} : {w[31], w[31:1]};
            default: res = w;
        endcase
        return res;
    endfunction

    // Step size and the datapath result for the current SHIFT cycle.
    always_comb begin
        two_step  = (r_q >= 5'd2);
        r_next    = r_q - (two_step ? 5'd2 : 5'd1);
        w_shifted = shift_step(w_q, l_q, two_step);
    end

    // Next-state and datapath-load decisions.
    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        r_d      = r_q;
        l_d      = l_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    w_d = bus.data_in;
                    r_d = bus.shamt;
                    l_d = bus.op;
                    if ((bus.shamt == 5'd0) || (bus.op == 2'b11)) begin
                        result_d = bus.data_in;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // A new start here is deliberately ignored, not queued.
                w_d = w_shifted;
                r_d = r_next;
                if (r_next == 5'd0) begin
                    result_d = w_shifted;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight shift.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            w_q      <= 32'd0;
            r_q      <= 5'd0;
            l_q      <= 2'b00;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            w_q      <= w_d;
            r_q      <= r_d;
            l_q      <= l_d;
            result_q <= result_d;
        end
    end

    // Outputs are registered or decoded from state only.
    always_comb begin
        bus.busy   = (state_q == ST_SHIFT);
        bus.done   = (state_q == ST_DONE);
        bus.result = result_q;
    end

endmodule

// File: tb/tb_iter_shift_unit.sv
// Bench for iter_shift_unit: directed vector table, randomized shifts
// against an arithmetic reference model, and hand-written sequences for
// mid-shift restart, mid-shift reset and back-to-back operation.
module tb_iter_shift_unit;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    iter_shift_unit_if bus ();

    iter_shift_unit dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  shamt;
        logic [31:0] data;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Reference: shift result straight from the ISA meaning of each op.
    function automatic logic [31:0] model_res(input logic [1:0] op, input logic [4:0] sh,
                                              input logic [31:0] d);
        if (sh == 5'd0 || op == 2'b11) return d;
        case (op)
            2'b00:   return d << sh;
            2'b01:   return d >> sh;
            default: return $unsigned($signed(d) >>> sh);
        endcase
    endfunction

    // Reference latency from start edge to Done: ceil(shamt/2)+1.
    function automatic int model_lat(input logic [1:0] op, input logic [4:0] sh);
        if (sh == 5'd0 || op == 2'b11) return 1;
        return (int'(sh) + 1) / 2 + 1;
    endfunction

    // Called at the negedge where start/operands are already set; lets the
    // accept edge pass, releases start, then waits for Done (bounded).
    task automatic wait_done(output logic [31:0] res, output int lat,
                             output int bcnt, output int ovl);
        @(negedge clk);
        bus.start   = 1'b0;
        bus.data_in = $urandom;
        bus.shamt   = 5'($urandom);
        bus.op      = 2'($urandom);
        lat = 0; bcnt = 0; ovl = 0;
        for (int i = 1; i <= 40; i++) begin
            if (bus.busy) bcnt++;
            if (bus.busy && bus.done) ovl++;
            if (bus.done) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        res = bus.result;
    endtask

    task automatic run_shift(input string name, input logic [1:0] op, input logic [4:0] sh,
                             input logic [31:0] d, input logic [31:0] exp_res, input int exp_lat);
        logic [31:0] res;
        int lat, bcnt, ovl;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.shamt = sh; bus.data_in = d;
        wait_done(res, lat, bcnt, ovl);
        check({name, "_result"}, res, exp_res);
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_busy_cycles"}, 32'(bcnt), 32'(exp_lat - 1));
        check({name, "_busy_done_overlap"}, 32'(ovl), 32'd0);
    endtask

    vec_t vecs[9];

    initial begin
        logic [31:0] res, r1;
        int lat, bcnt, ovl, dcnt;
        total = 0; bad = 0;

        vecs[0] = '{2'b00, 5'd31, 32'h0000_0001, 32'h8000_0000, 17};
        vecs[1] = '{2'b10, 5'd5,  32'h8000_0000, 32'hFC00_0000, 4};
        vecs[2] = '{2'b01, 5'd5,  32'h8000_0000, 32'h0400_0000, 4};
        vecs[3] = '{2'b01, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1};
        vecs[4] = '{2'b11, 5'd7,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1};
        vecs[5] = '{2'b10, 5'd31, 32'h7FFF_FFFF, 32'h0000_0000, 17};
        vecs[6] = '{2'b10, 5'd1,  32'h8000_0000, 32'hC000_0000, 2};
        vecs[7] = '{2'b01, 5'd31, 32'hFFFF_FFFF, 32'h0000_0001, 17};
        vecs[8] = '{2'b10, 5'd2,  32'h8000_0001, 32'hE000_0000, 2};

        bus.start = 1'b0; bus.op = 2'b00; bus.shamt = 5'd0; bus.data_in = 32'd0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_result", bus.result, 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);

        foreach (vecs[i])
            run_shift($sformatf("vec%0d", i), vecs[i].op, vecs[i].shamt, vecs[i].data,
                      vecs[i].exp_res, vecs[i].exp_lat);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic [4:0]  sh;
            logic [31:0] d;
            op = 2'($urandom_range(0, 3));
            sh = 5'($urandom);
            d  = $urandom;
            run_shift($sformatf("rand%0d", i), op, sh, d, model_res(op, sh, d), model_lat(op, sh));
        end

        // Start re-pulsed mid-shift must be ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.shamt = 5'd9; bus.data_in = 32'h0000_0003;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0; dcnt = 0; r1 = 32'd0;
        for (int i = 1; i <= 25; i++) begin
            if (i == 2) begin
                bus.start = 1'b1; bus.op = 2'b01; bus.shamt = 5'd3; bus.data_in = 32'h1234_5678;
            end
            if (i == 3) bus.start = 1'b0;
            if (bus.done) begin
                dcnt++;
                if (dcnt == 1) begin
                    lat = i;
                    r1  = bus.result;
                end
            end
            @(negedge clk);
        end
        check("restart_result", r1, 32'h0000_0600);
        check("restart_latency", 32'(lat), 32'd6);
        check("restart_done_count", 32'(dcnt), 32'd1);

        // Reset during SHIFT of an SLL by 20.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.shamt = 5'd20; bus.data_in = 32'h0000_0001;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset_busy", 32'(bus.busy), 32'd0);
        check("midreset_done", 32'(bus.done), 32'd0);
        check("midreset_result", bus.result, 32'd0);
        dcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) dcnt++;
            @(negedge clk);
        end
        check("midreset_no_done", 32'(dcnt), 32'd0);
        run_shift("after_reset", 2'b10, 5'd4, 32'h8000_0000, 32'hF800_0000, 3);

        // Back-to-back: new start held during the DONE cycle.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b01; bus.shamt = 5'd4; bus.data_in = 32'hF000_0000;
        wait_done(res, lat, bcnt, ovl);
        check("b2b_first_result", res, 32'h0F00_0000);
        check("b2b_first_latency", 32'(lat), 32'd3);
        bus.start = 1'b1; bus.op = 2'b00; bus.shamt = 5'd16; bus.data_in = 32'h0000_FFFF;
        wait_done(res, lat, bcnt, ovl);
        check("b2b_second_result", res, 32'hFFFF_0000);
        check("b2b_gap", 32'(lat), 32'd9);
        check("b2b_busy_cycles", 32'(bcnt), 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
